motor_drive_array: RTL and testbench
====================================

Name: motor_drive_array

Overview:
- Parametrised multi-channel DC-motor drive block, successor to the fixed two-wheel drive test block.
- Each channel takes a signed duty command and produces a glitch-free PWM plus the IN1/IN2 direction pair for a TB6612-class H-bridge.
- Each channel counts encoder feedback edges over a fixed sample window.
- A per-channel direction FSM inserts a timed brake on every direction reversal.

Parameters:
CH_NUM, 2, number of motor channels
PWM_WIDTH, 8, duty magnitude width; PWM period = 2**PWM_WIDTH-1 ticks
PWM_DIV, 16, clk cycles per PWM tick
SAMPLE_CNT, 16384, clk cycles per feedback sample window
CNT_WIDTH, 16, edge counter width per channel
DEAD_CYCLES, 1024, clk cycles of brake on a direction reversal
RAMP_STEP, 4, max duty-magnitude change per PWM period (used only with SOFT_START_EN)

Ports:
clk  in  1  system clock, 125 MHz
n_rst  in  1  asynchronous active-low reset
enable  in  1  1 = drive enabled; 0 = standby
duty  in  CH_NUM*(PWM_WIDTH+1)  signed two's-complement duty per channel (ch0 in LSBs); >0 fwd, <0 rev
fb  in  CH_NUM  raw asynchronous encoder pulse per channel
fb_cnt  out  CH_NUM*CNT_WIDTH  rising-edge count of the last completed window per channel
fb_valid  out  1  one-cycle pulse when fb_cnt updates
pwm  out  CH_NUM  PWM per channel
in1  out  CH_NUM  bridge IN1 per channel
in2  out  CH_NUM  bridge IN2 per channel
stnby  out  1  bridge STBY, active-high run

Behaviour:
- Clock and reset: one clock, clk. Reset n_rst is asynchronous and active-low.
- Reset state: all outputs 0; all counters 0; every channel FSM in STOP.
- Feedback synchronisation: each fb bit passes through a 2-FF synchroniser, then a rising-edge detector, giving 3 cycles of latency from pin to count.
- Edge counter: saturates at 2**CNT_WIDTH-1; it does not wrap.
- Window timer: counts 0..SAMPLE_CNT-1. On the terminal cycle:
  - every channel's count, including an edge detected in that same cycle, is latched to fb_cnt;
  - counters clear to 0;
  - fb_valid=1 on the following cycle, aligned with the new fb_cnt.
- Feedback counting runs regardless of enable.
- PWM tick: a prescaler produces one tick every PWM_DIV cycles. The PWM counter steps 0..2**PWM_WIDTH-2 per tick and then wraps.
- Duty sampling: duty is sampled only when the PWM counter wraps to 0, so the output is glitch-free.
  - Magnitude = |duty|, saturated to 2**PWM_WIDTH-1; the most negative value maps to the max.
  - pwm = (counter < magnitude). Magnitude 0 gives constant 0; the max gives constant 1.
- Per-channel FSM states: STOP, FWD, REV, BRAKE.
  - Sampled duty 0 → STOP from any state.
  - STOP + duty>0 → FWD; STOP + duty<0 → REV.
  - FWD + duty<0, or REV + duty>0 → BRAKE. The dead counter loads DEAD_CYCLES.
  - BRAKE exits when the dead counter reaches 0, to FWD/REV per the latest sampled sign, or to STOP if it is 0.
  - A sign flip during BRAKE does not restart the counter.
- Per-state outputs:
  - STOP: in1=0, in2=0, pwm=0.
  - FWD: in1=1, in2=0.
  - REV: in1=0, in2=1.
  - BRAKE: in1=1, in2=1, pwm=0.
- Output timing: in1, in2 and pwm are registered, one cycle after the state/compare.
- Standby: stnby = registered enable.
  - enable=0 forces every FSM to STOP immediately, irrespective of the PWM period.
  - On enable rise, duty is taken at the next PWM wrap.
- Reset mid-run: all outputs drop to 0 asynchronously and window/PWM counters restart from 0.

Optional Feature:
- Macro SOFT_START_EN.
- Defined: at each PWM wrap, the effective magnitude moves toward the commanded magnitude by at most RAMP_STEP.
  - STOP and BRAKE reset the effective magnitude to 0.
  - A reversal therefore ramps up from 0 after the brake.
- Undefined: the effective magnitude equals the commanded magnitude at each wrap.
- FSM and feedback behaviour are identical in both cases.

Test Plan:
- Bench parameters: PWM_WIDTH=4, PWM_DIV=1, SAMPLE_CNT=100, DEAD_CYCLES=20, CH_NUM=2.
- Reset: n_rst=0 mid-run → pwm, in1, in2, stnby, fb_cnt, fb_valid all 0 within the same cycle.
- Duty: enable=1, duty ch0=+5 → stnby=1, in1=1, in2=0, pwm high 5 of every 15 cycles; duty=+15 → pwm constantly 1; duty=-16 → saturates to 15 with in1=0, in2=1.
- Reversal: ch0 +8 → -8 → in1=in2=1, pwm=0 for 20 cycles, then in2=1, pwm 8/15 duty; duty=0 mid-brake → STOP after the brake.
- Feedback: fb0 3 one-cycle pulses and fb1 7 one-cycle pulses within one window → fb_valid pulse, fb_cnt ch0=3, ch1=7; next window with no pulses → 0; fb held toggling every cycle with CNT_WIDTH=4 → saturates at 15.
- Standby: enable 1→0 during FWD → next cycle STOP outputs and stnby=0; fb counting continues.
- SOFT_START_EN, RAMP_STEP=4: duty 0→+15 → effective magnitude over successive periods 4, 8, 12, 15.

Source files
------------

// File: rtl/motor_drive_array.sv
// Multi-channel DC-motor drive: signed duty -> glitch-free PWM + IN1/IN2 for a
// TB6612-class bridge, with timed brake on reversal and windowed encoder counts.
// Optional build macro SOFT_START_EN adds a per-period magnitude ramp.
module motor_drive_array #(
  parameter int CH_NUM      = 2,
  parameter int PWM_WIDTH   = 8,
  parameter int PWM_DIV     = 16,
  parameter int SAMPLE_CNT  = 16384,
  parameter int CNT_WIDTH   = 16,
  parameter int DEAD_CYCLES = 1024,
  parameter int RAMP_STEP   = 4
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic                             enable,
  input  logic [CH_NUM*(PWM_WIDTH+1)-1:0]  duty,
  input  logic [CH_NUM-1:0]                fb,
  output logic [CH_NUM*CNT_WIDTH-1:0]      fb_cnt,
  output logic                             fb_valid,
  output logic [CH_NUM-1:0]                pwm,
  output logic [CH_NUM-1:0]                in1,
  output logic [CH_NUM-1:0]                in2,
  output logic                             stnby
);

  localparam int DW = PWM_WIDTH + 1;
  localparam logic [PWM_WIDTH-1:0] MAG_MAX  = '1;
  localparam logic [PWM_WIDTH-1:0] PWM_LAST = MAG_MAX - PWM_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  localparam int DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PWM_DIV - 1);

  localparam int WIN_W = (SAMPLE_CNT > 1) ? $clog2(SAMPLE_CNT) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SAMPLE_CNT - 1);

  localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES);
  localparam logic [DEAD_W-1:0] DEAD_ONE  = DEAD_W'(1);

`ifdef SOFT_START_EN
  localparam int RAMP_LIM = (RAMP_STEP > (2**PWM_WIDTH - 1)) ? (2**PWM_WIDTH - 1) : RAMP_STEP;
  localparam logic [PWM_WIDTH-1:0] RAMP = PWM_WIDTH'(RAMP_LIM);
`endif

  typedef enum logic [1:0] {STOP, FWD, REV, BRAKE} state_t;

  // ---------------------------------------------------------------------------
  // Shared timebase: PWM prescaler/counter, feedback window, standby
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0]     pre_cnt;
  logic [PWM_WIDTH-1:0] pwm_cnt;
  logic [WIN_W-1:0]     win_cnt;
  logic                 tick;
  logic                 wrap;
  logic                 win_end;

  assign tick    = (pre_cnt == DIV_LAST);
  assign wrap    = tick && (pwm_cnt == PWM_LAST);
  assign win_end = (win_cnt == WIN_LAST);

  // NOTE: state is updated with <= only, so every flop samples pre-edge values
  // regardless of block ordering; reset is asynchronous on the sensitivity list.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pre_cnt  <= '0;
      pwm_cnt  <= '0;
      win_cnt  <= '0;
      fb_valid <= 1'b0;
      stnby    <= 1'b0;
    end else begin
      pre_cnt  <= tick ? '0 : pre_cnt + DIV_W'(1);
      if (tick) pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + PWM_WIDTH'(1);
      win_cnt  <= win_end ? '0 : win_cnt + WIN_W'(1);
      fb_valid <= win_end;
      stnby    <= enable;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel drive and feedback
  // ---------------------------------------------------------------------------
  for (genvar ch = 0; ch < CH_NUM; ch++) begin : g_ch
    logic [DW-1:0]        d;
    logic [DW-1:0]        d_neg;
    logic [PWM_WIDTH-1:0] cmd_mag;
    logic                 cmd_pos;
    logic                 cmd_neg;
    logic                 pos_q;
    logic                 neg_q;
    logic                 exit_pos;
    logic                 exit_neg;
    state_t               state;
    logic [DEAD_W-1:0]    dead;
    logic [PWM_WIDTH-1:0] eff;
    logic                 pwm_q;
    logic                 in1_q;
    logic                 in2_q;
    logic                 run;

    assign d       = duty[ch*DW +: DW];
    assign d_neg   = '0 - d;
    assign cmd_neg = d[PWM_WIDTH];
    assign cmd_pos = ~d[PWM_WIDTH] & (|d);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
      cmd_mag = d[PWM_WIDTH-1:0];
      if (d[PWM_WIDTH]) cmd_mag = d_neg[PWM_WIDTH] ? MAG_MAX : d_neg[PWM_WIDTH-1:0];
    end

    // Brake exit follows the newest sample, including one taken this very cycle.
    assign exit_pos = wrap ? cmd_pos : pos_q;
    assign exit_neg = wrap ? cmd_neg : neg_q;

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        state <= STOP;
        dead  <= '0;
        pos_q <= 1'b0;
        neg_q <= 1'b0;
      end else begin
        if (wrap) begin
          pos_q <= cmd_pos;
          neg_q <= cmd_neg;
        end
        if (!enable) begin
          state <= STOP;
          dead  <= '0;
        end else begin
          case (state)
            STOP: if (wrap) begin
              if (cmd_pos)      state <= FWD;
              else if (cmd_neg) state <= REV;
            end
            FWD: if (wrap) begin
              if (cmd_neg) begin
                state <= BRAKE;
                dead  <= DEAD_LOAD;
              end else if (!cmd_pos) state <= STOP;
            end
            REV: if (wrap) begin
              if (cmd_pos) begin
                state <= BRAKE;
                dead  <= DEAD_LOAD;
              end else if (!cmd_neg) state <= STOP;
            end
            BRAKE: begin
              // Sign changes while braking never reload the dead counter.
              dead <= dead - DEAD_ONE;
              if (dead <= DEAD_ONE) begin
                if (exit_pos)      state <= FWD;
                else if (exit_neg) state <= REV;
                else               state <= STOP;
              end
            end
            default: state <= STOP;
          endcase
        end
      end
    end

`ifdef SOFT_START_EN
    logic [PWM_WIDTH-1:0] base;
    logic [PWM_WIDTH-1:0] diff;
    logic [PWM_WIDTH-1:0] ramped;

    always_comb begin
      base   = (state == STOP) ? '0 : eff;
      ramped = cmd_mag;
      if (cmd_mag > base) begin
        diff = cmd_mag - base;
        if (diff > RAMP) ramped = base + RAMP;
      end else begin
        diff = base - cmd_mag;
        if (diff > RAMP) ramped = base - RAMP;
      end
    end

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)                                eff <= '0;
      else if (wrap && enable && state != BRAKE) eff <= ramped;
      else if (state == STOP || state == BRAKE)  eff <= '0;
    end
`else
    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)    eff <= '0;
      else if (wrap) eff <= cmd_mag;
    end
`endif

    // Outputs are gated by enable so standby takes effect on the next edge.
    assign run = enable && (state == FWD || state == REV);

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        pwm_q <= 1'b0;
        in1_q <= 1'b0;
        in2_q <= 1'b0;
      end else begin
        pwm_q <= run && (pwm_cnt < eff);
        in1_q <= enable && (state == FWD || state == BRAKE);
        in2_q <= enable && (state == REV || state == BRAKE);
      end
    end

    assign pwm[ch] = pwm_q;
    assign in1[ch] = in1_q;
    assign in2[ch] = in2_q;

    // Feedback: 2-FF synchroniser, rising-edge detect, saturating window count.
    logic                 s1, s2, s3;
    logic                 rise;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [CNT_WIDTH-1:0] cnt_q;

    assign rise    = s2 & ~s3;
    assign cnt_inc = (rise && cnt != CNT_MAX) ? cnt + CNT_WIDTH'(1) : cnt;

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        s3    <= 1'b0;
        cnt   <= '0;
        cnt_q <= '0;
      end else begin
        s1 <= fb[ch];
        s2 <= s1;
        s3 <= s2;
        if (win_end) begin
          cnt_q <= cnt_inc;
          cnt   <= '0;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end

    assign fb_cnt[ch*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end

endmodule

// File: tb/tb_motor_drive_array.sv
// Directed self-checking bench for motor_drive_array (small parameter set).
// Expected ramp values follow SOFT_START_EN when the bench is built with it.
module tb_motor_drive_array;

  localparam int CH  = 2;
  localparam int PW  = 4;
  localparam int CW  = 4;
  localparam int DW  = PW + 1;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              enable;
  logic [CH*DW-1:0]  duty;
  logic [CH-1:0]     fb;
  logic [CH*CW-1:0]  fb_cnt;
  logic              fb_valid;
  logic [CH-1:0]     pwm;
  logic [CH-1:0]     in1;
  logic [CH-1:0]     in2;
  logic              stnby;

  int errors = 0;
  int checks = 0;

  motor_drive_array #(
    .CH_NUM(CH), .PWM_WIDTH(PW), .PWM_DIV(1), .SAMPLE_CNT(100),
    .CNT_WIDTH(CW), .DEAD_CYCLES(20), .RAMP_STEP(4)
  ) dut (
    .clk(clk), .n_rst(n_rst), .enable(enable), .duty(duty), .fb(fb),
    .fb_cnt(fb_cnt), .fb_valid(fb_valid), .pwm(pwm), .in1(in1), .in2(in2),
    .stnby(stnby)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_duty(input int ch, input logic [DW-1:0] v);
    duty[ch*DW +: DW] = v;
  endtask

  // Count high cycles of each channel's pwm over n consecutive samples.
  task automatic count_high(input int n, output int hi0, output int hi1);
    hi0 = 0;
    hi1 = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hi0 += int'(pwm[0]);
      hi1 += int'(pwm[1]);
    end
  endtask

  task automatic wait_valid(output bit found);
    found = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (fb_valid) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_brake(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in1[0] && in2[0]) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    n_rst = 1'b0; enable = 1'b0; duty = '0; fb = '0;
    tick(3);
    checks++; if (pwm !== 2'b00)      begin errors++; $display("FAIL reset_pwm got=%b exp=00", pwm); end
    checks++; if (in1 !== 2'b00)      begin errors++; $display("FAIL reset_in1 got=%b exp=00", in1); end
    checks++; if (in2 !== 2'b00)      begin errors++; $display("FAIL reset_in2 got=%b exp=00", in2); end
    checks++; if (stnby !== 1'b0)     begin errors++; $display("FAIL reset_stnby got=%b exp=0", stnby); end
    checks++; if (fb_cnt !== 8'h00)   begin errors++; $display("FAIL reset_fb_cnt got=%h exp=00", fb_cnt); end
    checks++; if (fb_valid !== 1'b0)  begin errors++; $display("FAIL reset_fb_valid got=%b exp=0", fb_valid); end
  endtask

  task automatic test_duty;
    int h0, h1;
    n_rst = 1'b1; enable = 1'b1;
    set_duty(0, 5'd5);
    set_duty(1, 5'b11101);  // -3
    tick(60);
    checks++; if (stnby !== 1'b1)  begin errors++; $display("FAIL duty_stnby got=%b exp=1", stnby); end
    checks++; if (in1 !== 2'b01)   begin errors++; $display("FAIL duty_in1 got=%b exp=01", in1); end
    checks++; if (in2 !== 2'b10)   begin errors++; $display("FAIL duty_in2 got=%b exp=10", in2); end
    count_high(15, h0, h1);
    checks++; if (h0 != 5) begin errors++; $display("FAIL duty5_high got=%0d exp=5", h0); end
    checks++; if (h1 != 3) begin errors++; $display("FAIL duty_neg3_high got=%0d exp=3", h1); end
    set_duty(0, 5'd15);
    tick(60);
    count_high(15, h0, h1);
    checks++; if (h0 != 15) begin errors++; $display("FAIL duty15_high got=%0d exp=15", h0); end
    set_duty(0, 5'b10000);  // -16 saturates to 15
    tick(120);
    checks++; if (in1[0] !== 1'b0 || in2[0] !== 1'b1)
      begin errors++; $display("FAIL duty_neg16_dir got=%b%b exp=01", in1[0], in2[0]); end
    count_high(15, h0, h1);
    checks++; if (h0 != 15) begin errors++; $display("FAIL duty_neg16_high got=%0d exp=15", h0); end
  endtask

  task automatic test_reversal;
    int h0, h1, len, bad;
    bit found;
    set_duty(0, 5'd0);
    tick(30);
    set_duty(0, 5'd8);
    tick(60);
    checks++; if (in1[0] !== 1'b1 || in2[0] !== 1'b0)
      begin errors++; $display("FAIL rev_fwd_dir got=%b%b exp=10", in1[0], in2[0]); end
    set_duty(0, 5'b11000);  // -8
    wait_brake(found);
    checks++; if (!found) begin errors++; $display("FAIL rev_brake_start got=0 exp=1"); end
    len = 1; bad = int'(pwm[0]);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!(in1[0] && in2[0])) break;
      len++;
      bad += int'(pwm[0]);
    end
    checks++; if (len != 20) begin errors++; $display("FAIL rev_brake_len got=%0d exp=20", len); end
    checks++; if (bad != 0)  begin errors++; $display("FAIL rev_brake_pwm got=%0d exp=0", bad); end
    checks++; if (in1[0] !== 1'b0 || in2[0] !== 1'b1)
      begin errors++; $display("FAIL rev_after_brake got=%b%b exp=01", in1[0], in2[0]); end
    tick(80);
    count_high(15, h0, h1);
    checks++; if (h0 != 8) begin errors++; $display("FAIL rev_duty8_high got=%0d exp=8", h0); end

    // Duty goes to zero while braking: brake runs out, then STOP.
    set_duty(0, 5'd8);
    wait_brake(found);
    checks++; if (!found) begin errors++; $display("FAIL rev0_brake_start got=0 exp=1"); end
    len = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 2) set_duty(0, 5'd0);
      if (!(in1[0] && in2[0])) break;
      len++;
    end
    checks++; if (len != 20) begin errors++; $display("FAIL rev0_brake_len got=%0d exp=20", len); end
    checks++; if (in1[0] !== 1'b0 || in2[0] !== 1'b0 || pwm[0] !== 1'b0)
      begin errors++; $display("FAIL rev0_stop got=%b%b%b exp=000", in1[0], in2[0], pwm[0]); end
    tick(20);
    checks++; if (in1[0] !== 1'b0 || in2[0] !== 1'b0)
      begin errors++; $display("FAIL rev0_stop_hold got=%b%b exp=00", in1[0], in2[0]); end
  endtask

  task automatic test_feedback;
    bit found;
    fb = '0;
    wait_valid(found);
    for (int i = 0; i < 7; i++) begin
      fb = {1'b1, (i < 3)};
      @(negedge clk);
      fb = '0;
      @(negedge clk);
    end
    wait_valid(found);
    checks++; if (!found) begin errors++; $display("FAIL fb_valid_seen got=0 exp=1"); end
    checks++; if (fb_cnt[3:0] !== 4'd3) begin errors++; $display("FAIL fb_cnt0 got=%0d exp=3", fb_cnt[3:0]); end
    checks++; if (fb_cnt[7:4] !== 4'd7) begin errors++; $display("FAIL fb_cnt1 got=%0d exp=7", fb_cnt[7:4]); end
    @(negedge clk);
    checks++; if (fb_valid !== 1'b0) begin errors++; $display("FAIL fb_valid_pulse got=%b exp=0", fb_valid); end
    wait_valid(found);
    checks++; if (fb_cnt !== 8'h00) begin errors++; $display("FAIL fb_empty got=%h exp=00", fb_cnt); end
    found = 1'b0;
    for (int i = 0; i < 150; i++) begin
      fb = fb ^ 2'b11;
      @(negedge clk);
      if (fb_valid) begin
        found = 1'b1;
        break;
      end
    end
    fb = '0;
    checks++; if (!found || fb_cnt !== 8'hFF)
      begin errors++; $display("FAIL fb_saturate got=%h exp=ff", fb_cnt); end
  endtask

  task automatic test_standby_and_midreset;
    bit found;
    set_duty(0, 5'd5);
    set_duty(1, 5'd0);
    tick(60);
    checks++; if (in1[0] !== 1'b1) begin errors++; $display("FAIL stby_pre_fwd got=%b exp=1", in1[0]); end
    enable = 1'b0;
    @(negedge clk);
    checks++; if (stnby !== 1'b0) begin errors++; $display("FAIL stby_stnby got=%b exp=0", stnby); end
    checks++; if (in1 !== 2'b00 || in2 !== 2'b00 || pwm !== 2'b00)
      begin errors++; $display("FAIL stby_outputs got=%b/%b/%b exp=00/00/00", in1, in2, pwm); end
    wait_valid(found);
    for (int i = 0; i < 2; i++) begin
      fb = 2'b01;
      @(negedge clk);
      fb = '0;
      @(negedge clk);
    end
    enable = 1'b1;
    wait_valid(found);
    checks++; if (fb_cnt[3:0] !== 4'd2) begin errors++; $display("FAIL stby_fb_cnt got=%0d exp=2", fb_cnt[3:0]); end
    checks++; if (in1[0] !== 1'b1 || stnby !== 1'b1)
      begin errors++; $display("FAIL stby_resume got=%b%b exp=11", in1[0], stnby); end
    #2 n_rst = 1'b0;
    #1;
    checks++; if (pwm !== 2'b00 || in1 !== 2'b00 || in2 !== 2'b00)
      begin errors++; $display("FAIL midreset_drive got=%b/%b/%b exp=00/00/00", pwm, in1, in2); end
    checks++; if (stnby !== 1'b0 || fb_valid !== 1'b0 || fb_cnt !== 8'h00)
      begin errors++; $display("FAIL midreset_misc got=%b/%b/%h exp=0/0/00", stnby, fb_valid, fb_cnt); end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_soft_start;
    int exp_hi[4];
    int hi;
    bit found;
`ifdef SOFT_START_EN
    exp_hi = '{4, 8, 12, 15};
`else
    exp_hi = '{15, 15, 15, 15};
`endif
    set_duty(0, 5'd15);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (pwm[0]) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL ramp_start got=0 exp=1"); end
    for (int k = 0; k < 4; k++) begin
      hi = 0;
      for (int j = 0; j < 15; j++) begin
        hi += int'(pwm[0]);
        @(negedge clk);
      end
      checks++; if (hi != exp_hi[k]) begin errors++; $display("FAIL ramp_period%0d got=%0d exp=%0d", k, hi, exp_hi[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_duty();
    test_reversal();
    test_feedback();
    test_standby_and_midreset();
    test_soft_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
